// File: rtl/controle_acumulador.sv
// controle_acumulador: microsequencer expanding 8-bit commands into tx/ty/tula cycles for the X/Y/ULA datapath
// Ports:
//   clock, reset       rising-edge clock, asynchronous active-high reset
//   cmd_valid, cmd     command handshake input; cmd[7:4] opcode, cmd[3:0] argument
//   cmd_ready          high only while idle
//   tx, ty, tula       X/Y register control codes and ULA select (0 = add)
//   busy, done         busy while not idle; done pulses for one cycle at command end
//   erro               only with CTRL_ILLEGAL_OP_EN: set by an illegal opcode until the next legal command
// Optional macro: CTRL_ILLEGAL_OP_EN
module controle_acumulador #(
    parameter int CODE_W = 4,
    parameter int CNT_W = 4,
    parameter logic [CODE_W-1:0] ULA_IDLE = 4'd15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    input  logic [7:0]        cmd,
    output logic              cmd_ready,
    output logic [CODE_W-1:0] tx,
    output logic [CODE_W-1:0] ty,
    output logic [CODE_W-1:0] tula,
    output logic              busy,
    output logic              done
`ifdef CTRL_ILLEGAL_OP_EN
    ,
    output logic              erro
`endif
);
    localparam logic [CODE_W-1:0] C_CLEAR  = CODE_W'(0);
    localparam logic [CODE_W-1:0] C_LOAD   = CODE_W'(1);
    localparam logic [CODE_W-1:0] C_HOLD   = CODE_W'(2);
    localparam logic [CODE_W-1:0] C_SHIFTR = CODE_W'(3);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_op;
    logic [3:0]       w_op;
    logic [CNT_W-1:0] w_cnt;
    logic             w_exec;
    logic             w_add;

    assign w_op = cmd[7:4];
    // Opcodes 8-15 get count 0, so they run as NOP.
    assign w_cnt = (w_op == 4'd5 || w_op == 4'd6) ? CNT_W'(cmd[3:0]) :
                   (w_op == 4'd0 || w_op[3]) ? '0 : CNT_W'(1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_op    <= '0;
        end else begin
            case (r_state)
                IDLE: if (cmd_valid) begin
                    r_op    <= w_op;
                    r_cnt   <= w_cnt;
                    r_state <= (w_cnt != '0) ? EXEC : DONE;
                end
                EXEC: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) r_state <= DONE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef CTRL_ILLEGAL_OP_EN
    logic r_erro;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_erro <= 1'b0;
        else if (r_state == IDLE && cmd_valid) r_erro <= w_op[3];
    end
    assign erro = r_erro;
`endif

    // Codes are a Moore decode of state and latched opcode, so an asynchronous
    // reset restores the defaults without waiting for a clock edge.
    assign w_exec    = (r_state == EXEC);
    assign w_add     = (r_op == 4'd3 || r_op == 4'd5);
    assign tx        = !w_exec ? C_HOLD : r_op == 4'd2 ? C_LOAD : r_op == 4'd7 ? C_CLEAR : C_HOLD;
    assign ty        = !w_exec ? C_HOLD : r_op == 4'd1 ? C_CLEAR : w_add ? C_LOAD :
                       (r_op == 4'd4 || r_op == 4'd6) ? C_SHIFTR : C_HOLD;
    assign tula      = (w_exec && w_add) ? '0 : ULA_IDLE;
    assign cmd_ready = (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign done      = (r_state == DONE);
endmodule

// File: tb/tb_controle_acumulador.sv
// tb_controle_acumulador: directed plus random checks of controle_acumulador against a command-table model
module tb_controle_acumulador;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [7:0] cmd = 8'h00;
    logic       cmd_ready;
    logic [3:0] tx;
    logic [3:0] ty;
    logic [3:0] tula;
    logic       busy;
    logic       done;
`ifdef CTRL_ILLEGAL_OP_EN
    logic       erro;
`endif

    int n_tests = 0;
    int n_fail = 0;
    int x_m = 0;
    int y_m = 0;

    // Per-opcode expectations from the command table: codes in active cycles and repeat count.
    int tx_t[16]   = '{2, 2, 1, 2, 2, 2, 2, 0, 2, 2, 2, 2, 2, 2, 2, 2};
    int ty_t[16]   = '{2, 0, 2, 1, 3, 1, 3, 2, 2, 2, 2, 2, 2, 2, 2, 2};
    int tula_t[16] = '{15, 15, 15, 0, 15, 0, 15, 15, 15, 15, 15, 15, 15, 15, 15, 15};
    int cnt_t[16]  = '{0, 1, 1, 1, 1, -1, -1, 1, 0, 0, 0, 0, 0, 0, 0, 0};

    controle_acumulador dut (
        .clock(clock),
        .reset(reset),
        .cmd_valid(cmd_valid),
        .cmd(cmd),
        .cmd_ready(cmd_ready),
        .tx(tx),
        .ty(ty),
        .tula(tula),
        .busy(busy),
        .done(done)
`ifdef CTRL_ILLEGAL_OP_EN
        ,
        .erro(erro)
`endif
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int e_cnt(input logic [7:0] c);
        return (cnt_t[c[7:4]] < 0) ? int'(c[3:0]) : cnt_t[c[7:4]];
    endfunction

    // Advance one cycle, applying the X/Y datapath action of the codes seen this cycle (bus = 3).
    task automatic step();
        if (tx == 4'd0) x_m = 0;
        else if (tx == 4'd1) x_m = 3;
        if (ty == 4'd0) y_m = 0;
        else if (ty == 4'd1) y_m = (tula == 4'd0) ? y_m + x_m : 3;
        else if (ty == 4'd3) y_m = y_m >> 1;
        @(posedge clock);
        #1;
    endtask

    task automatic chk_out(input string tag, input int etx, input int ety, input int etula,
                           input bit ebusy, input bit edone, input bit eready);
        chk({tag, "_tx"}, 32'(tx), 32'(etx));
        chk({tag, "_ty"}, 32'(ty), 32'(ety));
        chk({tag, "_tula"}, 32'(tula), 32'(etula));
        chk({tag, "_busy"}, 32'(busy), 32'(ebusy));
        chk({tag, "_done"}, 32'(done), 32'(edone));
        chk({tag, "_ready"}, 32'(cmd_ready), 32'(eready));
    endtask

    task automatic run_cmd(input logic [7:0] c, input bit noise);
        int w;
        int n;
        w = 0;
        while (!cmd_ready && w < 20) begin
            step();
            w++;
        end
        chk("ready_wait", 32'(cmd_ready), 32'd1);
        n = e_cnt(c);
        cmd_valid = 1'b1;
        cmd = c;
        step();
        for (int k = 0; k < n; k++) begin
            cmd_valid = noise ? 1'($urandom) : 1'b0;
            cmd = noise ? 8'($urandom) : c;
            chk_out($sformatf("exec_%02h_%0d", c, k), tx_t[c[7:4]], ty_t[c[7:4]], tula_t[c[7:4]], 1, 0, 0);
            step();
        end
        cmd_valid = 1'b0;
        chk_out($sformatf("done_%02h", c), 2, 2, 15, 1, 1, 0);
`ifdef CTRL_ILLEGAL_OP_EN
        chk($sformatf("erro_%02h", c), 32'(erro), 32'(c[7]));
`endif
        step();
        chk_out($sformatf("idle_%02h", c), 2, 2, 15, 0, 0, 1);
    endtask

    initial begin
        #12;
        chk_out("reset", 2, 2, 15, 0, 0, 1);
        reset = 1'b0;
        @(posedge clock);
        #1;
        chk_out("post_reset", 2, 2, 15, 0, 0, 1);

        run_cmd(8'h30, 1'b0);
        run_cmd(8'h54, 1'b1);
        run_cmd(8'h60, 1'b1);
        run_cmd(8'h00, 1'b0);

        run_cmd(8'h70, 1'b0);
        run_cmd(8'h20, 1'b0);
        run_cmd(8'h10, 1'b0);
        run_cmd(8'h53, 1'b0);
        run_cmd(8'h62, 1'b0);
        chk("x_model", 32'(x_m), 32'd3);
        chk("y_model", 32'(y_m), 32'd2);

        run_cmd(8'hA5, 1'b1);
`ifdef CTRL_ILLEGAL_OP_EN
        step();
        chk("erro_hold", 32'(erro), 32'd1);
        cmd_valid = 1'b1;
        cmd = 8'h20;
        step();
        cmd_valid = 1'b0;
        chk("erro_clear", 32'(erro), 32'd0);
        step();
        step();
`endif

        for (int i = 0; i < 25; i++) run_cmd(8'($urandom), 1'($urandom));

        // Reset during the third active cycle of SHRN 9.
        cmd_valid = 1'b1;
        cmd = 8'h69;
        step();
        cmd_valid = 1'b0;
        step();
        step();
        chk_out("shrn_third", 2, 3, 15, 1, 0, 0);
        #2;
        reset = 1'b1;
        #1;
        chk_out("async_reset", 2, 2, 15, 0, 0, 1);
        #3;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk_out($sformatf("after_reset_%0d", i), 2, 2, 15, 0, 0, 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
